// File: rtl/trap_ctrl_if.sv
// Trap-cause handshake between trap_ctrl (master) and the host CPU-side consumer (slave).
// cause_valid rises together with a freshly latched trap_cause and holds until a one-clk
// cause_ack pulse; an ack seen while cause_valid is low is ignored.
interface trap_ctrl_if #(
  parameter int CAUSE_W = 3
);
  logic [CAUSE_W-1:0] trap_cause;
  logic               cause_valid;
  logic               cause_ack;

  modport master (
    output trap_cause,
    output cause_valid,
    input  cause_ack
  );

  modport slave (
    input  trap_cause,
    input  cause_valid,
    output cause_ack
  );
endinterface

// File: rtl/trap_ctrl.sv
// Z80 virtualization trap controller: collects I/O-violation and IRQ trap requests, raises NMI,
// tracks trapped/untrapped state across M1 cycles and latches the trap cause for the host.
module trap_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int CAUSE_W = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               m1_n,
  input  logic [NUM_SRC-1:0] io_violation,
  input  logic               irq_sys_n,
  input  logic               irq_intercept,
  input  logic               new_isr,
  input  logic               last_isr_untrap,
  input  logic               virtual_enabled,
  output logic               trap_state,
  output logic               nmi_n,
  output logic               capture_address,
  output logic [NUM_SRC-1:0] violation_pending,
  output logic [CNT_W-1:0]   trap_count,
  trap_ctrl_if.master        cause
);

  typedef enum logic {
    ST_UNTRAPPED = 1'b0,
    ST_TRAPPED   = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic                 m1_prev_q;
  logic [NUM_SRC-1:0]   io_prev_q;
  logic [NUM_SRC-1:0]   pend_q, pend_d;
  logic                 irq_sync_q, irq_sync_d;
  logic                 cap_q, cap_d;
  logic [CAUSE_W-1:0]   cause_q, cause_d;
  logic                 valid_q, valid_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 nmi_n_q, nmi_n_d;

  logic                 m1_fall, m1_rise;
  logic [NUM_SRC-1:0]   viol_edge;
  logic                 irq_req, trap_pending, trap_take;
  logic [CAUSE_W-1:0]   win_cause;

  assign m1_fall      = m1_prev_q & ~m1_n;
  assign m1_rise      = ~m1_prev_q & m1_n;
  assign viol_edge    = ~io_prev_q & io_violation;
  assign irq_req      = ~irq_sync_q & irq_intercept;
  assign trap_pending = irq_req | (|pend_q);

  // IRQ outranks every I/O source; among sources the lowest index wins.
  always_comb begin
    win_cause = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend_q[i]) win_cause = CAUSE_W'(i + 1);
    end
    if (irq_req) win_cause = '0;
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    cap_d      = cap_q;
    cause_d    = cause_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    trap_take  = 1'b0;
    irq_sync_d = m1_rise ? irq_sys_n : irq_sync_q;

    if (m1_fall) begin
      cap_d = 1'b0;
      case (state_q)
        ST_UNTRAPPED: begin
          if (!virtual_enabled) begin
            state_d = ST_TRAPPED;
          end else if (trap_pending && new_isr) begin
            state_d   = ST_TRAPPED;
            cap_d     = 1'b1;
            valid_d   = 1'b1;
            cause_d   = win_cause;
            trap_take = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          end
        end
        ST_TRAPPED: begin
          if (last_isr_untrap && virtual_enabled) state_d = ST_UNTRAPPED;
        end
        default: state_d = ST_TRAPPED;
      endcase
    end

    // A cause latched on this clock consumes any ack arriving in the same clock.
    if (cause.cause_ack && valid_q && !trap_take) begin
      valid_d = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (cause_q == CAUSE_W'(i + 1)) pend_d[i] = 1'b0;
      end
    end

    for (int i = 0; i < NUM_SRC; i++) begin
      if (viol_edge[i]) pend_d[i] = (state_q == ST_UNTRAPPED);
    end

    nmi_n_d = ~((((~irq_sync_d) & irq_intercept) | (|pend_d)) & (state_d == ST_UNTRAPPED));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_TRAPPED;
      m1_prev_q  <= 1'b1;
      io_prev_q  <= '0;
      pend_q     <= '0;
      irq_sync_q <= 1'b1;
      cap_q      <= 1'b0;
      cause_q    <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      nmi_n_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      m1_prev_q  <= m1_n;
      io_prev_q  <= io_violation;
      pend_q     <= pend_d;
      irq_sync_q <= irq_sync_d;
      cap_q      <= cap_d;
      cause_q    <= cause_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      nmi_n_q    <= nmi_n_d;
    end
  end

  assign trap_state        = (state_q == ST_TRAPPED);
  assign nmi_n             = nmi_n_q;
  assign capture_address   = cap_q | (last_isr_untrap & trap_state & virtual_enabled);
  assign violation_pending = pend_q;
  assign trap_count        = cnt_q;
  assign cause.trap_cause  = cause_q;
  assign cause.cause_valid = valid_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios plus random traffic, every cycle scored against a
// behavioural model through an expected-output queue, with spot checks on key scenario values.
module tb_trap_ctrl;
  localparam int NUM_SRC = 4;
  localparam int CAUSE_W = 3;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int W       = 4 + CAUSE_W + NUM_SRC + CNT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n, m1_n, irq_sys_n, irq_intercept, new_isr;
  logic               last_isr_untrap, virtual_enabled;
  logic [NUM_SRC-1:0] io_violation;
  logic               trap_state, nmi_n, capture_address;
  logic [NUM_SRC-1:0] violation_pending;
  logic [CNT_W-1:0]   trap_count;

  trap_ctrl_if #(.CAUSE_W(CAUSE_W)) cif ();

  trap_ctrl #(.NUM_SRC(NUM_SRC), .CAUSE_W(CAUSE_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m1_n             (m1_n),
    .io_violation     (io_violation),
    .irq_sys_n        (irq_sys_n),
    .irq_intercept    (irq_intercept),
    .new_isr          (new_isr),
    .last_isr_untrap  (last_isr_untrap),
    .virtual_enabled  (virtual_enabled),
    .trap_state       (trap_state),
    .nmi_n            (nmi_n),
    .capture_address  (capture_address),
    .violation_pending(violation_pending),
    .trap_count       (trap_count),
    .cause            (cif.master)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // Reference model state (behavioural, plain variables)
  bit               mt, mcap, mvalid, mirq_line, mprev_m1, mnmi;
  bit [NUM_SRC-1:0] mpend, mprev_io;
  int               mcause, mcount;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit fall, rise, irq_req, took, was_trapped;
    int old_cause;
    if (!reset_n) begin
      mt = 1; mcap = 0; mpend = '0; mirq_line = 1; mcause = 0; mvalid = 0;
      mcount = 0; mprev_m1 = 1; mprev_io = '0; mnmi = 1;
      return;
    end
    fall        = mprev_m1 && !m1_n;
    rise        = !mprev_m1 && m1_n;
    irq_req     = !mirq_line && irq_intercept;
    was_trapped = mt;
    old_cause   = mcause;
    took        = 0;
    if (fall) begin
      mcap = 0;
      if (!was_trapped && !virtual_enabled) begin
        mt = 1;
      end else if (!was_trapped && (irq_req || mpend != 0) && new_isr) begin
        mt = 1; mcap = 1; mvalid = 1; took = 1;
        mcount = (mcount < CNT_MAX) ? mcount + 1 : CNT_MAX;
        if (irq_req) mcause = 0;
        else begin
          for (int i = NUM_SRC - 1; i >= 0; i--) if (mpend[i]) mcause = i + 1;
        end
      end else if (was_trapped && last_isr_untrap && virtual_enabled) begin
        mt = 0;
      end
    end
    if (cif.cause_ack && mvalid && !took) begin
      mvalid = 0;
      if (old_cause >= 1) mpend[old_cause-1] = 0;
    end
    for (int i = 0; i < NUM_SRC; i++)
      if (!mprev_io[i] && io_violation[i]) mpend[i] = !was_trapped;
    if (rise) mirq_line = irq_sys_n;
    mprev_m1 = m1_n;
    mprev_io = io_violation;
    mnmi = !(((!mirq_line && irq_intercept) || mpend != 0) && !mt);
  endtask

  // Inputs held from negedge+1 until the next negedge+1, covering the edge and the sample.
  task automatic tick();
    bit cap_exp;
    @(posedge clk);
    model_step();
    cap_exp = mcap || (last_isr_untrap && mt && virtual_enabled);
    exp_q.push_back({mt, mnmi, cap_exp, mvalid, CAUSE_W'(mcause), mpend, CNT_W'(mcount)});
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {trap_state, nmi_n, capture_address, cif.cause_valid, cif.trap_cause,
           violation_pending, trap_count};
      check("trap_state",        16'(a[W-1]),   16'(e[W-1]));
      check("nmi_n",             16'(a[W-2]),   16'(e[W-2]));
      check("capture_address",   16'(a[W-3]),   16'(e[W-3]));
      check("cause_valid",       16'(a[W-4]),   16'(e[W-4]));
      check("trap_cause",        16'(a[W-5 -: CAUSE_W]), 16'(e[W-5 -: CAUSE_W]));
      check("violation_pending", 16'(a[NUM_SRC+CNT_W-1 -: NUM_SRC]),
                                 16'(e[NUM_SRC+CNT_W-1 -: NUM_SRC]));
      check("trap_count",        16'(a[CNT_W-1:0]), 16'(e[CNT_W-1:0]));
    end
  end

  initial begin
    reset_n = 0; m1_n = 1; io_violation = '0; irq_sys_n = 1; irq_intercept = 0;
    new_isr = 0; last_isr_untrap = 0; virtual_enabled = 1; cif.cause_ack = 0;
    repeat (3) tick();
    check("reset_trap_state", 16'(trap_state), 16'd1);
    check("reset_nmi_n", 16'(nmi_n), 16'd1);
    reset_n = 1; tick();

    // Untrap after reset
    m1_n = 0; last_isr_untrap = 1; tick();
    m1_n = 1; last_isr_untrap = 0; tick();
    check("untrap_state", 16'(trap_state), 16'd0);
    check("untrap_nmi_n", 16'(nmi_n), 16'd1);
    check("untrap_count", 16'(trap_count), 16'd0);

    // Source 2 violation, then trap on ISR entry
    io_violation = 4'b0100; tick(); io_violation = '0; tick();
    check("src2_pending", 16'(violation_pending), 16'b0100);
    check("src2_nmi_n", 16'(nmi_n), 16'd0);
    m1_n = 0; new_isr = 1; tick();
    check("src2_cause", 16'(cif.trap_cause), 16'd3);
    check("src2_valid", 16'(cif.cause_valid), 16'd1);
    check("src2_count", 16'(trap_count), 16'd1);
    check("src2_capture", 16'(capture_address), 16'd1);
    m1_n = 1; new_isr = 0; repeat (2) tick();
    check("capture_held", 16'(capture_address), 16'd1);
    m1_n = 0; tick();
    check("capture_dropped", 16'(capture_address), 16'd0);
    m1_n = 1; tick();
    cif.cause_ack = 1; tick(); cif.cause_ack = 0; tick();

    // IRQ priority over pending source 0
    m1_n = 0; last_isr_untrap = 1; tick(); m1_n = 1; last_isr_untrap = 0; tick();
    irq_intercept = 1; irq_sys_n = 0; m1_n = 0; tick(); m1_n = 1; tick();
    io_violation = 4'b0001; tick(); io_violation = '0; tick();
    m1_n = 0; new_isr = 1; tick(); m1_n = 1; new_isr = 0; tick();
    check("irq_cause", 16'(cif.trap_cause), 16'd0);

    // Ack on the latch clock is consumed; violation while trapped clears its bit
    irq_sys_n = 1; m1_n = 0; last_isr_untrap = 1; tick();
    m1_n = 1; last_isr_untrap = 0; tick();
    io_violation = 4'b0010; tick(); io_violation = '0; tick();
    m1_n = 0; new_isr = 1; cif.cause_ack = 1; tick();
    check("ack_on_latch_valid", 16'(cif.cause_valid), 16'd1);
    check("ack_on_latch_cause", 16'(cif.trap_cause), 16'd1);
    m1_n = 1; new_isr = 0; cif.cause_ack = 0; tick();
    io_violation = 4'b0010; tick(); io_violation = '0; tick();
    check("trapped_viol_pending", 16'(violation_pending), 16'b0001);
    check("trapped_viol_nmi_n", 16'(nmi_n), 16'd1);
    cif.cause_ack = 1; tick(); cif.cause_ack = 0; tick();

    // Counter saturation, then virtualization off forces a trap
    m1_n = 0; last_isr_untrap = 1; tick();
    m1_n = 1; last_isr_untrap = 0; irq_sys_n = 0; tick();
    m1_n = 0; new_isr = 1; tick(); m1_n = 1; new_isr = 0; tick();
    check("sat_count", 16'(trap_count), 16'd3);
    m1_n = 0; last_isr_untrap = 1; tick(); m1_n = 1; last_isr_untrap = 0; tick();
    virtual_enabled = 0; m1_n = 0; new_isr = 1; tick();
    check("virt_off_state", 16'(trap_state), 16'd1);
    check("virt_off_count", 16'(trap_count), 16'd3);
    m1_n = 1; new_isr = 0; virtual_enabled = 1; tick();

    // Reset during a trap with an M1 fall and a violation edge in the same clock
    reset_n = 0; m1_n = 0; io_violation = 4'b1000; tick();
    reset_n = 1; m1_n = 1; io_violation = '0; irq_sys_n = 1; tick();

    for (int k = 0; k < 800; k++) begin
      reset_n         = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 2) == 0) m1_n = ~m1_n;
      io_violation    = ($urandom_range(0, 3) == 0) ? NUM_SRC'($urandom) : io_violation & NUM_SRC'($urandom);
      irq_sys_n       = ($urandom_range(0, 3) != 0);
      irq_intercept   = ($urandom_range(0, 1) != 0);
      new_isr         = ($urandom_range(0, 1) != 0);
      last_isr_untrap = ($urandom_range(0, 2) == 0);
      virtual_enabled = ($urandom_range(0, 9) != 0);
      cif.cause_ack   = ($urandom_range(0, 3) == 0);
      tick();
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
